// File: rtl/dff_bist_pkg.sv
// -----------------------------------------------------------------------------
// dff_bist_pkg
// Shared definitions for the single-bit storage-element BIST driver:
//   - state_t    : controller state encoding (IDLE/RUN/DRAIN/DONE)
//   - LFSR_W     : LFSR width
//   - LFSR_TAPS  : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - lfsr_next  : one Fibonacci advance, shifting left with feedback in bit 0
// -----------------------------------------------------------------------------
package dff_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned LFSR_W    = 8;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// -----------------------------------------------------------------------------
// bist_lfsr8
// 8-bit Fibonacci LFSR producing the BIST D stream.
// Ports:
//   CLK     in   rising-edge clock
//   RST     in   asynchronous active-high reset, loads RST_VAL
//   LOAD    in   load SEED (takes priority over ADV)
//   ADV     in   advance the register by one step
//   SEED    in   [7:0] value loaded when LOAD=1
//   BIT_OUT out  current MSB, i.e. the bit issued before the next advance
// -----------------------------------------------------------------------------
module bist_lfsr8
    import dff_bist_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic       ADV,
    input  logic [7:0] SEED,
    output logic       BIT_OUT
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lfsr <= RST_VAL;
        end else if (LOAD) begin
            r_lfsr <= SEED;
        end else if (ADV) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign BIT_OUT = r_lfsr[LFSR_W-1];

endmodule

// File: rtl/dff_bist_driver.sv
// -----------------------------------------------------------------------------
// dff_bist_driver
// Built-in self-test driver/checker for a single-bit posedge storage element.
// Drives a pseudo-random D stream, samples Q after DUT_LAT edges and counts
// mismatches against a delayed copy of the issued bits.
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous active-high reset
//   START    in   begin a run (honoured only in IDLE or DONE)
//   Q_IN     in   Q of the element under test
//   D_OUT    out  registered D to the element under test
//   BUSY     out  high in RUN and DRAIN
//   DONE     out  high in DONE
//   PASS     out  valid with DONE; 1 iff ERR_CNT==0
//   ERR_CNT  out  [7:0] saturating mismatch count
//   PAT_CNT  out  [15:0] bits issued in the current run
// -----------------------------------------------------------------------------
module dff_bist_driver
    import dff_bist_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 20,
    parameter int unsigned DUT_LAT      = 1,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        Q_IN,
    output logic        D_OUT,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERR_CNT,
    output logic [15:0] PAT_CNT
);

    localparam int unsigned DEPTH      = DUT_LAT + 1;
    localparam logic [15:0] PAT_LAST   = 16'(NUM_PATTERNS);
    localparam logic [2:0]  DRAIN_LAST = 3'(DUT_LAT);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_start;
    logic              w_issue;
    logic              w_lfsr_bit;
    logic              r_d_out;
    logic [7:0]        r_err_cnt;
    logic [15:0]       r_pat_cnt;
    logic [2:0]        r_drain_cnt;
    logic [DEPTH-1:0]  r_exp_pipe;
    logic [DEPTH-1:0]  r_vld_pipe;

    bist_lfsr8 #(
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RST     (RST),
        .LOAD    (w_start),
        .ADV     (w_issue),
        .SEED    (LFSR_SEED),
        .BIT_OUT (w_lfsr_bit)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RUN exits on the edge after the last bit is issued (PAT_CNT already
    // equal to NUM_PATTERNS); that edge issues nothing and feeds valid=0.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_start      = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_pat_cnt == PAT_LAST) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_d_out     <= 1'b0;
            r_err_cnt   <= '0;
            r_pat_cnt   <= '0;
            r_drain_cnt <= '0;
            r_exp_pipe  <= '0;
            r_vld_pipe  <= '0;
        end else begin
            r_exp_pipe <= {r_exp_pipe[DEPTH-2:0], w_lfsr_bit};
            r_vld_pipe <= {r_vld_pipe[DEPTH-2:0], w_issue};

            if (w_issue) begin
                r_d_out <= w_lfsr_bit;
            end

            if (w_start) begin
                r_pat_cnt <= '0;
            end else if (w_issue) begin
                r_pat_cnt <= r_pat_cnt + 16'd1;
            end

            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 3'd1 : '0;

            // Case-inequality so an X/Z on Q_IN is scored as a mismatch.
            if (w_start) begin
                r_err_cnt <= '0;
            end else if (r_vld_pipe[DEPTH-1] && (Q_IN !== r_exp_pipe[DEPTH-1])
                         && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign D_OUT   = r_d_out;
    assign BUSY    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign DONE    = (r_state == ST_DONE);
    assign PASS    = (r_state == ST_DONE) && (r_err_cnt == '0);
    assign ERR_CNT = r_err_cnt;
    assign PAT_CNT = r_pat_cnt;

endmodule

// File: tb/tb_dff_bist_driver.sv
// -----------------------------------------------------------------------------
// tb_dff_bist_driver
// Directed bench for dff_bist_driver: two instances (20 and 300 patterns),
// each driving a behavioural posedge flop whose Q path can be good, inverted
// or stuck at 0. Expected D bits come from an independent LFSR model and are
// queued at START, then popped as the DUT issues each bit.
// -----------------------------------------------------------------------------
module tb_dff_bist_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [1:0]  mode;

    logic        d_a, busy_a, done_a, pass_a, ff_a = 1'b0, q_a;
    logic [7:0]  err_a;
    logic [15:0] pat_a;
    logic        d_b, busy_b, done_b, pass_b, ff_b = 1'b0, q_b;
    logic [7:0]  err_b;
    logic [15:0] pat_b;

    logic        m_d, m_busy, m_done, m_pass;
    logic [7:0]  m_err;
    logic [15:0] m_pat;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];
    int ones20;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ff_a <= d_a;
        ff_b <= d_b;
    end

    assign q_a = (mode == 2'd0) ? ff_a : (mode == 2'd1) ? ~ff_a : 1'b0;
    assign q_b = (mode == 2'd0) ? ff_b : (mode == 2'd1) ? ~ff_b : 1'b0;

    dff_bist_driver #(.NUM_PATTERNS(20), .DUT_LAT(1), .LFSR_SEED(8'hA5)) u_dut_a (
        .CLK(clk), .RST(rst), .START(start & ~sel), .Q_IN(q_a), .D_OUT(d_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a), .PAT_CNT(pat_a)
    );

    dff_bist_driver #(.NUM_PATTERNS(300), .DUT_LAT(1), .LFSR_SEED(8'hA5)) u_dut_b (
        .CLK(clk), .RST(rst), .START(start & sel), .Q_IN(q_b), .D_OUT(d_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b), .PAT_CNT(pat_b)
    );

    assign m_d    = sel ? d_b    : d_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_pass = sel ? pass_b : pass_a;
    assign m_err  = sel ? err_b  : err_a;
    assign m_pat  = sel ? pat_b  : pat_a;

    function automatic logic [7:0] mstep(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_stream(input int n);
        logic [7:0] s;
        s = 8'hA5;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[7]);
            s = mstep(s);
        end
    endtask

    // Assumes the START-sampling edge has just passed (sampled #1 after it).
    task automatic run_body(input int n, input int exp_err, input logic exp_pass);
        int   edges;
        logic [15:0] prev;
        bit   e;
        push_stream(n);
        chk("start_busy", {31'd0, m_busy}, 32'd1);
        chk("start_pat", {16'd0, m_pat}, 32'd0);
        edges = 0;
        prev  = 16'd0;
        while (!m_done && edges < n + 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (m_pat != prev) begin
                prev = m_pat;
                if (exp_q.size() == 0) begin
                    chk("extra_bit", {16'd0, m_pat}, n);
                end else begin
                    e = exp_q.pop_front();
                    chk("d_out", {31'd0, m_d}, {31'd0, e});
                end
            end
        end
        chk("latency", edges, n + 3);
        chk("pat_cnt", {16'd0, m_pat}, n);
        chk("err_cnt", {24'd0, m_err}, exp_err);
        chk("pass", {31'd0, m_pass}, {31'd0, exp_pass});
        chk("queue_left", exp_q.size(), 0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        mode  = 2'd0;

        s = 8'hA5;
        ones20 = 0;
        for (int i = 0; i < 20; i++) begin
            ones20 += int'(s[7]);
            s = mstep(s);
        end

        #3;
        chk("rst_d", {31'd0, d_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_pass", {31'd0, pass_a}, 32'd0);
        chk("rst_err", {24'd0, err_a}, 32'd0);
        chk("rst_pat", {16'd0, pat_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Good flop
        start_pulse();
        run_body(20, 0, 1'b1);

        // Inverted Q path
        mode = 2'd1;
        start_pulse();
        run_body(20, 20, 1'b0);

        // Q stuck at 0
        mode = 2'd2;
        start_pulse();
        run_body(20, ones20, 1'b0);

        // 300 patterns, inverted: saturates
        sel  = 1'b1;
        mode = 2'd1;
        start_pulse();
        run_body(300, 255, 1'b0);

        // Reset mid-run at PAT_CNT=10
        sel  = 1'b0;
        mode = 2'd0;
        start_pulse();
        guard = 0;
        while (m_pat != 16'd10 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_pat10", {16'd0, m_pat}, 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_d", {31'd0, m_d}, 32'd0);
        chk("abort_busy", {31'd0, m_busy}, 32'd0);
        chk("abort_done", {31'd0, m_done}, 32'd0);
        chk("abort_pass", {31'd0, m_pass}, 32'd0);
        chk("abort_err", {24'd0, m_err}, 32'd0);
        chk("abort_pat", {16'd0, m_pat}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_pulse();
        run_body(20, 0, 1'b1);

        // START held high: no restart before DONE, then restart reproduces run
        mode = 2'd2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        run_body(20, ones20, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        run_body(20, ones20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
